ctrl_unit: RTL and testbench
============================

Name: ctrl_unit

Overview:
- Instruction sequencer for the 8-bit accumulator uProcessor. It is the driving end of the ALU/register interface.
- Fetches an instruction word from program memory, decodes it, and drives ALUCode, the accumulator and carry clock enables (A_CE, CY_CE), register-file controls and PC sequencing.
- Sits between program ROM and the datapath (ALU, Aku, Reg_CY, register file).

Parameters:
- PC_W, 8: program counter width; program space 2^PC_W words.
- REG_AW, 2: register-file address width; taken from operand bits [REG_AW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  12  program word at address pc: [11:8] opcode, [7:0] operand. Combinational ROM, valid in the same cycle.
- pc  out  PC_W  program counter / ROM address.
- zf  in  1  accumulator-zero flag from datapath (A==0).
- cy  in  1  carry flag from Reg_CY.
- ALUCode  out  3  ALU operation select.
- r_sel  out  1  ALU R source: 0 = register file, 1 = immediate.
- imm  out  8  immediate operand (IR[7:0]).
- r_addr  out  REG_AW  register-file address.
- A_CE  out  1  accumulator load strobe.
- CY_CE  out  1  carry register load strobe.
- cy_clr  out  1  carry clear strobe.
- r_we  out  1  register-file write strobe; data = accumulator.
- halted  out  1  core stopped.

Behaviour:
- ALUCode map: 0 PASS R, 1 ADD, 2 ADC (uses Ci), 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT A.
- FSM states: FETCH, DECODE, EXEC, HALT. Every non-halt instruction takes exactly 3 cycles: FETCH→DECODE→EXEC→FETCH.
- FETCH: pc drives the ROM; IR <= instr at the clock edge.
- DECODE: ALUCode, r_sel, imm and r_addr are driven from IR. All strobes stay 0.
- EXEC: the same combinational controls are held, and exactly one cycle of the opcode's strobes is asserted. pc is updated at the end of EXEC.
- ALUCode/r_sel/r_addr/imm are don't-care in FETCH; they are driven 0.
- Opcodes:
  - 0 NOP: no strobes.
  - 1 LDI: PASS, r_sel=1, A_CE.
  - 2 LD: PASS, r_sel=0, A_CE.
  - 3 ST: r_we.
  - 4 ADD, 5 ADC, 6 SUB: codes 1/2/3, r_sel=0, A_CE+CY_CE.
  - 7 AND, 8 OR, 9 XOR: codes 4/5/6, A_CE only.
  - A ADDI: code 1, r_sel=1, A_CE+CY_CE.
  - B JMP: pc <= IR[PC_W-1:0].
  - C JZ: jump if zf.
  - D JC: jump if cy.
  - E CLC: cy_clr.
  - F HLT: EXEC → HALT.
- Flag sampling: zf and cy are sampled in the EXEC cycle only.
- Non-jump or untaken jump: pc <= pc+1, modulo 2^PC_W (pc=2^PC_W-1 wraps to 0).
- HALT:
  - halted=1, all strobes 0, pc frozen at HLT address+1.
  - Exit only by reset.
- Reset (any state, including mid-EXEC):
  - At the next edge: state=FETCH, pc=0, IR=0, all strobes 0, halted=0, ALUCode=0, r_sel=0.
  - Strobes that would have fired in an EXEC cycle coinciding with rst=1 are suppressed (rst has priority).
- Strobes are mutually consistent: at most one of {A_CE, r_we, cy_clr} per cycle. CY_CE only ever appears together with A_CE.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - The FSM remains in FETCH (IR not loaded, pc held) until step=1. One instruction then executes and the FSM waits in the next FETCH.
  - step held high free-runs.
  - step is ignored in DECODE, EXEC and HALT.
- Undefined: no step port; FETCH always advances.

Test Plan:
- Reset check: rst=1 for 2 cycles mid-EXEC of ADD → next cycle pc=0, state FETCH, A_CE=CY_CE=0, halted=0.
- LDI timing: ROM[0]=LDI 0x08 (0x108), ROM[1]=ADDI 0x04 (0xA04).
  - Cycle 3: ALUCode=0, r_sel=1, imm=0x08, A_CE=1.
  - Cycle 6: ALUCode=1, imm=0x04, A_CE=CY_CE=1.
  - pc sequence 0,0,0,1,1,1,2.
- Register ops: ROM = ST R2 (0x302), LD R2 (0x202), SUB R1 (0x601).
  - r_we pulses once with r_addr=2.
  - LD gives ALUCode=0, r_sel=0, r_addr=2.
  - SUB gives ALUCode=3, r_addr=1, A_CE+CY_CE.
- Conditional jumps: JZ 0x10 with zf=1 → pc=0x10; JZ 0x10 with zf=0 → pc=prev+1; JC 0x20 with cy=1 → pc=0x20. No strobes are asserted on any of them.
- Wrap and halt: JMP 0xFF, ROM[0xFF]=NOP → pc wraps to 0x00. ROM[0]=HLT → halted=1 forever, pc=1, strobes 0; rst releases to pc=0.
- CTRL_SINGLE_STEP_EN: step=0 for 10 cycles → pc and outputs static. One step pulse → exactly one instruction (3 cycles), then stall again.

Source files
------------

// File: rtl/ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module : ctrl_unit_if
// Brief  : Sequencer <-> ROM/datapath bundle; step exists only with CTRL_SINGLE_STEP_EN.
// Rev    : 1.0
// ============================================================================
interface ctrl_unit_if #(
  parameter int PC_W   = 8,
  parameter int REG_AW = 2
);
  logic [11:0]       instr;
  logic [PC_W-1:0]   pc;
  logic              zf;
  logic              cy;
  logic [2:0]        ALUCode;
  logic              r_sel;
  logic [7:0]        imm;
  logic [REG_AW-1:0] r_addr;
  logic              A_CE;
  logic              CY_CE;
  logic              cy_clr;
  logic              r_we;
  logic              halted;
`ifdef CTRL_SINGLE_STEP_EN
  logic              step;
`endif

  modport master (
`ifdef CTRL_SINGLE_STEP_EN
    input  step,
`endif
    input  instr, zf, cy,
    output pc, ALUCode, r_sel, imm, r_addr, A_CE, CY_CE, cy_clr, r_we, halted
  );

  modport slave (
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    output instr, zf, cy,
    input  pc, ALUCode, r_sel, imm, r_addr, A_CE, CY_CE, cy_clr, r_we, halted
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : ctrl_unit
// Brief  : FETCH/DECODE/EXEC sequencer for the 8-bit accumulator core.
//          Define CTRL_SINGLE_STEP_EN to gate FETCH with bus.step.
// Rev    : 1.0
// ============================================================================
module ctrl_unit #(
  parameter int PC_W   = 8,
  parameter int REG_AW = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ctrl_unit_if.master bus
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADC  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_CLC  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam int TGT_W = (PC_W < 8) ? PC_W : 8;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] alu;
    logic       rsel;
    logic       ace;
    logic       cyce;
    logic       clr;
    logic       we;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_LDI:  begin d.rsel = 1'b1; d.ace = 1'b1; end
      OP_LD:   d.ace = 1'b1;
      OP_ST:   d.we  = 1'b1;
      OP_ADD:  begin d.alu = 3'd1; d.ace = 1'b1; d.cyce = 1'b1; end
      OP_ADC:  begin d.alu = 3'd2; d.ace = 1'b1; d.cyce = 1'b1; end
      OP_SUB:  begin d.alu = 3'd3; d.ace = 1'b1; d.cyce = 1'b1; end
      OP_AND:  begin d.alu = 3'd4; d.ace = 1'b1; end
      OP_OR:   begin d.alu = 3'd5; d.ace = 1'b1; end
      OP_XOR:  begin d.alu = 3'd6; d.ace = 1'b1; end
      OP_ADDI: begin d.alu = 3'd1; d.rsel = 1'b1; d.ace = 1'b1; d.cyce = 1'b1; end
      OP_CLC:  d.clr = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [11:0]       ir_q;
  logic [2:0]        alu_q;
  logic              rsel_q;
  logic [7:0]        imm_q;
  logic [REG_AW-1:0] raddr_q;
  logic              ace_q;
  logic              cyce_q;
  logic              clr_q;
  logic              we_q;
  logic              halted_q;

  dec_t              fetch_dec_d;
  dec_t              exec_dec_d;
  logic              take_jump_d;
  logic              fetch_go_d;
  logic [PC_W-1:0]   pc_inc_d;
  logic [PC_W-1:0]   jump_tgt_d;

  assign fetch_dec_d = decode(bus.instr[11:8]);
  assign exec_dec_d  = decode(ir_q[11:8]);
  assign pc_inc_d    = pc_q + PC_W'(1);
  assign jump_tgt_d  = PC_W'(ir_q[TGT_W-1:0]);

`ifdef CTRL_SINGLE_STEP_EN
  assign fetch_go_d = bus.step;
`else
  assign fetch_go_d = 1'b1;
`endif

  // Flags are only consumed on the EXEC edge, so sampling them here is safe.
  always_comb begin
    take_jump_d = 1'b0;
    case (ir_q[11:8])
      OP_JMP:  take_jump_d = 1'b1;
      OP_JZ:   take_jump_d = bus.zf;
      OP_JC:   take_jump_d = bus.cy;
      default: take_jump_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      alu_q    <= '0;
      rsel_q   <= 1'b0;
      imm_q    <= '0;
      raddr_q  <= '0;
      ace_q    <= 1'b0;
      cyce_q   <= 1'b0;
      clr_q    <= 1'b0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      ace_q  <= 1'b0;
      cyce_q <= 1'b0;
      clr_q  <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (fetch_go_d) begin
            ir_q    <= bus.instr;
            alu_q   <= fetch_dec_d.alu;
            rsel_q  <= fetch_dec_d.rsel;
            imm_q   <= bus.instr[7:0];
            raddr_q <= bus.instr[REG_AW-1:0];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Strobes are loaded here so they are high for exactly the EXEC cycle.
          ace_q   <= exec_dec_d.ace;
          cyce_q  <= exec_dec_d.cyce;
          clr_q   <= exec_dec_d.clr;
          we_q    <= exec_dec_d.we;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          alu_q   <= '0;
          rsel_q  <= 1'b0;
          imm_q   <= '0;
          raddr_q <= '0;
          pc_q    <= take_jump_d ? jump_tgt_d : pc_inc_d;
          if (ir_q[11:8] == OP_HLT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  // rst masks the strobes in the same cycle so a reset mid-EXEC commits nothing.
  assign bus.A_CE    = ace_q  & ~rst;
  assign bus.CY_CE   = cyce_q & ~rst;
  assign bus.cy_clr  = clr_q  & ~rst;
  assign bus.r_we    = we_q   & ~rst;
  assign bus.pc      = pc_q;
  assign bus.ALUCode = alu_q;
  assign bus.r_sel   = rsel_q;
  assign bus.imm     = imm_q;
  assign bus.r_addr  = raddr_q;
  assign bus.halted  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ctrl_unit
// Brief  : Directed vector bench for ctrl_unit with a behavioural program ROM.
// Rev    : 1.0
// ============================================================================
module tb_ctrl_unit;

  logic clk;
  logic rst;
  logic [11:0] rom [256];
  int n_pass;
  int n_total;

  ctrl_unit_if #(.PC_W(8), .REG_AW(2)) bus ();

  ctrl_unit #(.PC_W(8), .REG_AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.instr = rom[bus.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ins;
    logic        zf;
    logic        cy;
    logic        chk_alu;
    logic [2:0]  alu;
    logic        rsel;
    logic [3:0]  stb;
    logic [7:0]  npc;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [3:0] stb();
    return {bus.A_CE, bus.CY_CE, bus.cy_clr, bus.r_we};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int k = 0; k < 256; k++) rom[k] = 12'h000;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pc_seq [7];
    logic       ok;
    int         we_cnt;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus.zf  = 1'b0;
    bus.cy  = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    //            ins       zf    cy    chk   alu   rsel  {A,CY,clr,we} next pc
    vecs[0]  = '{12'h108, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 4'b1000, 8'h01};
    vecs[1]  = '{12'h202, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'b1000, 8'h01};
    vecs[2]  = '{12'h302, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001, 8'h01};
    vecs[3]  = '{12'h401, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'b1100, 8'h01};
    vecs[4]  = '{12'h503, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'b1100, 8'h01};
    vecs[5]  = '{12'h601, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 4'b1100, 8'h01};
    vecs[6]  = '{12'h700, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 4'b1000, 8'h01};
    vecs[7]  = '{12'h8FF, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 4'b1000, 8'h01};
    vecs[8]  = '{12'h900, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 4'b1000, 8'h01};
    vecs[9]  = '{12'hA04, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'b1100, 8'h01};
    vecs[10] = '{12'hB42, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h42};
    vecs[11] = '{12'hC10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h10};
    vecs[12] = '{12'hC10, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h01};
    vecs[13] = '{12'hD20, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h20};
    vecs[14] = '{12'hD20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h01};
    vecs[15] = '{12'hE00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0010, 8'h01};
    vecs[16] = '{12'h055, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h01};

    // Single-instruction vectors; flags are inverted during DECODE to prove EXEC-only sampling.
    for (int i = 0; i < 17; i++) begin
      clear_rom();
      rom[0] = vecs[i].ins;
      reset_dut();
      chk($sformatf("v%0d fetch pc", i), 32'(bus.pc), 32'h0);
      chk($sformatf("v%0d fetch strobes", i), 32'(stb()), 32'h0);
      chk($sformatf("v%0d fetch alucode", i), 32'(bus.ALUCode), 32'h0);
      chk($sformatf("v%0d fetch halted", i), 32'(bus.halted), 32'h0);
      bus.zf = ~vecs[i].zf;
      bus.cy = ~vecs[i].cy;
      tick();
      if (vecs[i].chk_alu) begin
        chk($sformatf("v%0d decode alucode", i), 32'(bus.ALUCode), 32'(vecs[i].alu));
        chk($sformatf("v%0d decode r_sel", i), 32'(bus.r_sel), 32'(vecs[i].rsel));
      end
      chk($sformatf("v%0d decode imm", i), 32'(bus.imm), 32'(vecs[i].ins[7:0]));
      chk($sformatf("v%0d decode r_addr", i), 32'(bus.r_addr), 32'(vecs[i].ins[1:0]));
      chk($sformatf("v%0d decode strobes", i), 32'(stb()), 32'h0);
      bus.zf = vecs[i].zf;
      bus.cy = vecs[i].cy;
      tick();
      if (vecs[i].chk_alu) begin
        chk($sformatf("v%0d exec alucode", i), 32'(bus.ALUCode), 32'(vecs[i].alu));
        chk($sformatf("v%0d exec r_sel", i), 32'(bus.r_sel), 32'(vecs[i].rsel));
      end
      chk($sformatf("v%0d exec imm", i), 32'(bus.imm), 32'(vecs[i].ins[7:0]));
      chk($sformatf("v%0d exec r_addr", i), 32'(bus.r_addr), 32'(vecs[i].ins[1:0]));
      chk($sformatf("v%0d exec strobes", i), 32'(stb()), 32'(vecs[i].stb));
      chk($sformatf("v%0d exec pc", i), 32'(bus.pc), 32'h0);
      tick();
      chk($sformatf("v%0d next pc", i), 32'(bus.pc), 32'(vecs[i].npc));
      chk($sformatf("v%0d next strobes", i), 32'(stb()), 32'h0);
      chk($sformatf("v%0d next imm", i), 32'(bus.imm), 32'h0);
    end
    bus.zf = 1'b0;
    bus.cy = 1'b0;

    // LDI then ADDI: cycle-accurate pc and control timing.
    clear_rom();
    rom[0] = 12'h108;
    rom[1] = 12'hA04;
    pc_seq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02};
    reset_dut();
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("ldi cycle%0d pc", c), 32'(bus.pc), 32'(pc_seq[c-1]));
      if (c == 3) begin
        chk("ldi c3 alucode", 32'(bus.ALUCode), 32'd0);
        chk("ldi c3 r_sel", 32'(bus.r_sel), 32'd1);
        chk("ldi c3 imm", 32'(bus.imm), 32'h08);
        chk("ldi c3 strobes", 32'(stb()), 32'b1000);
      end
      if (c == 6) begin
        chk("addi c6 alucode", 32'(bus.ALUCode), 32'd1);
        chk("addi c6 imm", 32'(bus.imm), 32'h04);
        chk("addi c6 strobes", 32'(stb()), 32'b1100);
      end
      tick();
    end

    // ST R2, LD R2, SUB R1.
    clear_rom();
    rom[0] = 12'h302;
    rom[1] = 12'h202;
    rom[2] = 12'h601;
    reset_dut();
    we_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      if (bus.r_we) begin
        we_cnt++;
        chk("st r_addr", 32'(bus.r_addr), 32'd2);
      end
      if (c == 6) begin
        chk("ld alucode", 32'(bus.ALUCode), 32'd0);
        chk("ld r_sel", 32'(bus.r_sel), 32'd0);
        chk("ld r_addr", 32'(bus.r_addr), 32'd2);
      end
      if (c == 9) begin
        chk("sub alucode", 32'(bus.ALUCode), 32'd3);
        chk("sub r_addr", 32'(bus.r_addr), 32'd1);
        chk("sub strobes", 32'(stb()), 32'b1100);
      end
      tick();
    end
    chk("st r_we pulse count", 32'(we_cnt), 32'd1);

    // Reset asserted during EXEC of ADD at pc=1.
    clear_rom();
    rom[1] = 12'h401;
    reset_dut();
    repeat (5) tick();
    chk("pre-reset exec pc", 32'(bus.pc), 32'd1);
    chk("pre-reset exec strobes", 32'(stb()), 32'b1100);
    rst = 1'b1;
    #1;
    chk("reset suppresses strobes", 32'(stb()), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post-reset pc", 32'(bus.pc), 32'd0);
    chk("post-reset strobes", 32'(stb()), 32'h0);
    chk("post-reset halted", 32'(bus.halted), 32'd0);
    chk("post-reset alucode", 32'(bus.ALUCode), 32'd0);
    chk("post-reset r_sel", 32'(bus.r_sel), 32'd0);
    tick();
    chk("post-reset decode pc", 32'(bus.pc), 32'd0);

    // JMP 0xFF, NOP at 0xFF wraps pc to 0, then HLT at 0.
    clear_rom();
    rom[0]   = 12'hBFF;
    rom[255] = 12'h000;
    reset_dut();
    repeat (3) tick();
    chk("jmp to 0xff", 32'(bus.pc), 32'hFF);
    repeat (3) tick();
    chk("pc wrap", 32'(bus.pc), 32'h00);
    rom[0] = 12'hF00;
    repeat (3) tick();
    chk("hlt halted", 32'(bus.halted), 32'd1);
    chk("hlt pc", 32'(bus.pc), 32'd1);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.halted !== 1'b1 || bus.pc !== 8'd1 || stb() !== 4'b0000) ok = 1'b0;
      tick();
    end
    chk("halt stable 10 cycles", 32'(ok), 32'd1);
    reset_dut();
    chk("halt release pc", 32'(bus.pc), 32'd0);
    chk("halt release halted", 32'(bus.halted), 32'd0);

`ifdef CTRL_SINGLE_STEP_EN
    clear_rom();
    rom[0] = 12'h108;
    rom[1] = 12'h10F;
    bus.step = 1'b0;
    reset_dut();
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.pc !== 8'd0 || stb() !== 4'b0000 || bus.imm !== 8'h00 || bus.ALUCode !== 3'd0) ok = 1'b0;
      tick();
    end
    chk("step stall static", 32'(ok), 32'd1);
    bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
    chk("step decode r_sel", 32'(bus.r_sel), 32'd1);
    chk("step decode imm", 32'(bus.imm), 32'h08);
    tick();
    chk("step exec strobes", 32'(stb()), 32'b1000);
    tick();
    chk("step next pc", 32'(bus.pc), 32'd1);
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (bus.pc !== 8'd1 || stb() !== 4'b0000 || bus.imm !== 8'h00) ok = 1'b0;
      tick();
    end
    chk("step stall after one instr", 32'(ok), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
